dbg_run_ctrl: RTL
=================

DBG_RUN_CTRL -- requirements
Module: dbg_run_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of register-file words dumped.
REQ-002 SHALL have parameter RST_CYC, default 4, meaning core-reset pulse length in clk_i cycles (1..255).
REQ-003 SHALL have clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid_i / cmd_ready_o, input / output, 1 each, host command handshake.
REQ-006 SHALL have cmd_i, input, 3, opcode: 0 NOP, 1 RESET, 2 RUN, 3 STEP, 4 HALT, 5 DUMP, 6 SETBP.
REQ-007 SHALL have cmd_arg_i, input, 32, carrying the STEP count or the SETBP address.
REQ-008 SHALL have pc_i, input, 32, the core PC; and pc_ov_i, input, 1, end-of-program flag.
REQ-009 SHALL have proc_run_en_o, output, 1, core clock enable; and proc_reset_o, output, 1, active-high core reset.
REQ-010 SHALL have reg_addr_o, output, 5, regfile debug read address; and reg_rdata_i, input, 32, asynchronous read data.
REQ-011 SHALL have dump_valid_o / dump_ready_i, output / input, 1 each; and dump_data_o, output, 32, the dump stream.
REQ-012 SHALL have state_o, output, 3 (current state); and halt_cause_o, output, 2 (0 host, 1 step done, 2 pc_ov, 3 breakpoint).

Function
REQ-013 SHALL implement states RESET, IDLE, RUN, STEP, DONE and DUMP.
REQ-014 SHALL hold proc_reset_o=1 in RESET for exactly RST_CYC cycles, then enter IDLE with halt_cause_o=0.
REQ-015 SHALL accept a command when cmd_valid_i and cmd_ready_o are both high at a rising edge; cmd_ready_o SHALL be 0 in RESET and DUMP and 1 otherwise.
REQ-016 SHALL, in IDLE or DONE, enter RESET on RESET, RUN on RUN, STEP on STEP (counter=cmd_arg_i, 0 treated as 1) and DUMP on DUMP, and treat NOP as a no-op.
REQ-017 SHALL, in RUN or STEP, go to IDLE on HALT (cause 0) and to RESET on RESET, and accept-and-ignore all other opcodes.
REQ-018 SHALL drive proc_run_en_o = (state is RUN or STEP) AND NOT pc_ov_i AND NOT bp_hit, combinationally, so that no instruction executes at the overflow or breakpoint PC.
REQ-019 SHALL keep proc_run_en_o high for exactly N enabled cycles in STEP, then enter IDLE with cause 1.
REQ-020 SHALL, when pc_ov_i is sampled high in RUN or STEP, enter DONE with cause 2; pc_ov_i has priority over step-count expiry in the same cycle.
REQ-021 SHALL, in DUMP, sweep reg_addr_o from 0 to NREG-1, register reg_rdata_i one cycle after each address update, and assert dump_valid_o with dump_data_o stable until dump_ready_i.
REQ-022 SHALL advance the address on each handshake, leaving one invalid cycle between words.
REQ-023 SHALL return from DUMP to the state it was entered from (IDLE or DONE), cause unchanged, after the handshake of word NREG-1.
REQ-024 SHALL hold reg_addr_o at 0 outside DUMP.
REQ-025 SHALL let a HALT command, or cmd_valid_i, arriving in the same cycle as pc_ov_i in RUN be overridden by pc_ov_i, which wins.

Reset
REQ-026 SHALL, while rst_n is low: state=RESET, proc_reset_o=1, proc_run_en_o=0, cmd_ready_o=0, dump_valid_o=0, dump_data_o=0, reg_addr_o=0, halt_cause_o=0, step counter=0, breakpoint cleared.
REQ-027 SHALL, on rst_n assertion mid-RUN, mid-STEP or mid-DUMP, abort immediately with no stream completion, and run the full RST_CYC sequence after release.

Configuration
REQ-028 SHALL, with DBG_RUN_CTRL_BREAKPOINT_EN defined: let SETBP store cmd_arg_i[31:2] and set bp_valid; bp_hit = bp_valid AND pc_i[31:2]==bp_addr in RUN or STEP, excluding the first cycle after entry; bp_hit enters IDLE with cause 3.
REQ-029 SHALL, without DBG_RUN_CTRL_BREAKPOINT_EN: accept SETBP as a NOP, tie bp_hit to 0, never report cause 3, and instantiate no breakpoint registers.

Structure
REQ-030 SHALL place state encoding, opcode constants and halt-cause codes in shared package dbg_run_pkg.
REQ-031 SHALL implement the DUMP address and stream logic in sub-module dbg_reg_dump, started and finished by one-cycle pulses.

Verification
REQ-032 SHALL check: rst_n release -> proc_reset_o high 4 cycles, then IDLE and cmd_ready_o=1.
REQ-033 SHALL check: STEP with cmd_arg_i=3 -> proc_run_en_o high exactly 3 cycles, then IDLE with halt_cause_o=1; cmd_arg_i=0 -> exactly 1 cycle.
REQ-034 SHALL check: RUN, then pc_ov_i=1 at PC 0x48 -> proc_run_en_o low that same cycle, then DONE with cause 2.
REQ-035 SHALL check: DUMP with dump_ready_i toggling randomly and reg_rdata_i=addr*0x11111111 -> 32 words in order, each held until handshake, then return to the prior state.
REQ-036 SHALL check: with the macro, SETBP 0x10 then RUN -> stop with PC=0x10 and cause 3; a second RUN advances past 0x10.
REQ-037 SHALL check: rst_n low during DUMP word 7 -> dump_valid_o=0 at once, then a full reset sequence.

Source files
------------

// File: rtl/dbg_run_pkg.sv
// Shared encodings for the debug run controller: FSM states, host opcodes, halt causes.
// Pure declarations; no latency or flow control of its own.
package dbg_run_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_DUMP  = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RESET = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;
  localparam logic [2:0] OP_DUMP  = 3'd5;
  localparam logic [2:0] OP_SETBP = 3'd6;

  localparam logic [1:0] CAUSE_HOST = 2'd0;
  localparam logic [1:0] CAUSE_STEP = 2'd1;
  localparam logic [1:0] CAUSE_OV   = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

  function automatic logic is_active(state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/dbg_run_ctrl_if.sv
// Host-side bundle: command handshake (valid/ready) and register dump stream (valid/ready).
// Wires only; the controller is the slave on both channels.
interface dbg_run_ctrl_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_i;
  logic [31:0] cmd_arg_i;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [31:0] dump_data_o;

  modport slave  (input  cmd_valid_i, cmd_i, cmd_arg_i, dump_ready_i,
                  output cmd_ready_o, dump_valid_o, dump_data_o);
  modport master (output cmd_valid_i, cmd_i, cmd_arg_i, dump_ready_i,
                  input  cmd_ready_o, dump_valid_o, dump_data_o);
endinterface

// File: rtl/dbg_reg_dump.sv
// Register-file dump streamer: sweeps addresses 0..NREG-1 after a start pulse, pulses done on the last handshake.
// Data registered one cycle after each address update; word held until dump_ready_i, one idle cycle between words.
module dbg_reg_dump #(
  parameter int NREG = 32
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        done_o,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o
);
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hs, last;

  assign hs   = valid_q & dump_ready_i;
  assign last = (addr_q == 5'(NREG - 1));

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (start_i) begin
      busy_d  = 1'b1;
      valid_d = 1'b0;
      addr_d  = '0;
    end else if (hs) begin
      valid_d = 1'b0;
      if (last) begin
        busy_d = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 5'd1;
      end
    end else if (busy_q && !valid_q) begin
      // address has been stable for a full cycle, so the async read has settled
      valid_d = 1'b1;
      data_d  = reg_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign done_o       = hs & last;
  assign reg_addr_o   = addr_q;
  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: core reset/run/step/halt and regfile dump; breakpoint via DBG_RUN_CTRL_BREAKPOINT_EN.
// Run enable is combinational from state, pc_ov_i and breakpoint match; cmd_ready_o low in RESET and DUMP.
module dbg_run_ctrl
  import dbg_run_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int RST_CYC = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  dbg_run_ctrl_if.slave      host,
  input  logic [31:0]        pc_i,
  input  logic               pc_ov_i,
  output logic               proc_run_en_o,
  output logic               proc_reset_o,
  output logic [4:0]         reg_addr_o,
  input  logic [31:0]        reg_rdata_i,
  output logic [2:0]         state_o,
  output logic [1:0]         halt_cause_o
);
  state_t      state_q, state_d, ret_q, ret_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic        cmd_rdy, cmd_acc, run_en, bp_hit, dump_start, dump_done;

  assign cmd_acc = host.cmd_valid_i & cmd_rdy;

`ifdef DBG_RUN_CTRL_BREAKPOINT_EN
  logic [29:0] bp_addr_q;
  logic        bp_valid_q, run_prev_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bp_addr_q  <= '0;
      bp_valid_q <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      run_prev_q <= is_active(state_q);
      if (cmd_acc && host.cmd_i == OP_SETBP &&
          (state_q == ST_IDLE || state_q == ST_DONE)) begin
        bp_valid_q <= 1'b1;
        bp_addr_q  <= host.cmd_arg_i[31:2];
      end
    end
  end

  // run_prev_q masks the entry cycle so a resume from the breakpoint PC can advance
  assign bp_hit = bp_valid_q & run_prev_q & is_active(state_q) & (pc_i[31:2] == bp_addr_q);
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      ret_q      <= ST_IDLE;
      rst_cnt_q  <= '0;
      step_cnt_q <= '0;
      cause_q    <= CAUSE_HOST;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      rst_cnt_q  <= rst_cnt_d;
      step_cnt_q <= step_cnt_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    rst_cnt_d  = '0;
    step_cnt_d = step_cnt_q;
    cause_d    = cause_q;
    dump_start = 1'b0;
    case (state_q)
      ST_RESET: begin
        cause_d = CAUSE_HOST;
        if (rst_cnt_q == 8'(RST_CYC - 1)) state_d = ST_IDLE;
        else                              rst_cnt_d = rst_cnt_q + 8'd1;
      end
      ST_IDLE, ST_DONE: begin
        if (cmd_acc) begin
          case (host.cmd_i)
            OP_RESET: begin
              state_d = ST_RESET;
              cause_d = CAUSE_HOST;
            end
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: begin
              state_d    = ST_STEP;
              step_cnt_d = (host.cmd_arg_i == 32'd0) ? 32'd1 : host.cmd_arg_i;
            end
            OP_DUMP: begin
              state_d    = ST_DUMP;
              ret_d      = state_q;
              dump_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        // pc_ov_i outranks breakpoint, host commands and step expiry
        if (pc_ov_i) begin
          state_d = ST_DONE;
          cause_d = CAUSE_OV;
        end else if (bp_hit) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_BP;
        end else if (cmd_acc && host.cmd_i == OP_HALT) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_HOST;
        end else if (cmd_acc && host.cmd_i == OP_RESET) begin
          state_d = ST_RESET;
          cause_d = CAUSE_HOST;
        end else if (state_q == ST_STEP && run_en) begin
          step_cnt_d = step_cnt_q - 32'd1;
          if (step_cnt_q == 32'd1) begin
            state_d = ST_IDLE;
            cause_d = CAUSE_STEP;
          end
        end
      end
      ST_DUMP: if (dump_done) state_d = ret_q;
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    run_en       = is_active(state_q) & ~pc_ov_i & ~bp_hit;
    proc_reset_o = (state_q == ST_RESET);
    cmd_rdy      = (state_q != ST_RESET) && (state_q != ST_DUMP);
  end

  dbg_reg_dump #(.NREG(NREG)) u_dump (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .start_i      (dump_start),
    .done_o       (dump_done),
    .reg_addr_o   (reg_addr_o),
    .reg_rdata_i  (reg_rdata_i),
    .dump_valid_o (host.dump_valid_o),
    .dump_ready_i (host.dump_ready_i),
    .dump_data_o  (host.dump_data_o)
  );

  assign host.cmd_ready_o = cmd_rdy;
  assign proc_run_en_o    = run_en;
  assign state_o          = state_q;
  assign halt_cause_o     = cause_q;
endmodule
